// File: rtl/quant_seq.sv
// Job sequencer driving a fixed-latency quantizer from an accumulator stream,
// with a per-channel scale/zero-point table and a credit-guarded result FIFO.
module quant_seq #(
    parameter int ACC_W      = 48,
    parameter int SCALE_W    = 24,
    parameter int DATA_W     = 16,
    parameter int NUM_CH     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int QLAT       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_addr,
    input  logic [SCALE_W-1:0]        cfg_scale,
    input  logic [DATA_W-1:0]         cfg_zp,
    input  logic                      start,
    input  logic [$clog2(NUM_CH):0]   num_ch,
    input  logic [15:0]               num_beats,
    output logic                      busy,
    output logic                      done,
    input  logic                      acc_valid,
    output logic                      acc_ready,
    input  logic [ACC_W-1:0]          acc_data,
    output logic [ACC_W-1:0]          q_data_in,
    output logic [SCALE_W-1:0]        q_scale,
    output logic [DATA_W-1:0]         q_zero_point,
    input  logic [DATA_W-1:0]         q_data_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last
);
    localparam int AW = $clog2(NUM_CH);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state;
    logic [AW-1:0]      ch;
    logic [AW:0]        nch_r;
    logic [15:0]        beat_cnt;
    logic [15:0]        nbeats_r;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      occ;
    logic [QLAT:0]      sr_valid;
    logic [QLAT:0]      sr_last;
    logic [SCALE_W-1:0] scale_tab [NUM_CH];
    logic [DATA_W-1:0]  zp_tab [NUM_CH];
    logic [DATA_W-1:0]  data_mem [FIFO_DEPTH];
    logic               last_mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               accept;
    logic               pop;
    logic               push;
    logic               final_beat;

    // cnt covers both in-flight beats and FIFO occupancy, so a beat is only
    // accepted when a FIFO slot is guaranteed for its result.
    assign busy       = state != IDLE;
    assign acc_ready  = (state == RUN) && (cnt < DEPTH_C);
    assign accept     = acc_valid && acc_ready;
    assign final_beat = ({1'b0, beat_cnt} + 17'd1) == {1'b0, nbeats_r};
    assign push       = sr_valid[QLAT];
    assign out_valid  = occ != '0;
    assign pop        = out_valid && out_ready;
    assign out_data   = out_valid ? data_mem[rd_ptr] : '0;
    assign out_last   = out_valid && last_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            done         <= 1'b0;
            ch           <= '0;
            nch_r        <= '0;
            beat_cnt     <= '0;
            nbeats_r     <= '0;
            cnt          <= '0;
            sr_valid     <= '0;
            sr_last      <= '0;
            q_data_in    <= '0;
            q_scale      <= '0;
            q_zero_point <= '0;
        end else begin
            done     <= 1'b0;
            sr_valid <= {sr_valid[QLAT-1:0], accept};
            sr_last  <= {sr_last[QLAT-1:0], accept && final_beat};
            unique case ({accept, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: ;
            endcase
            if (accept) begin
                q_data_in    <= acc_data;
                q_scale      <= scale_tab[ch];
                q_zero_point <= zp_tab[ch];
                ch           <= ({1'b0, ch} == nch_r - 1'b1) ? '0 : ch + 1'b1;
                beat_cnt     <= beat_cnt + 16'd1;
            end
            case (state)
                IDLE: if (start) begin
                    state    <= RUN;
                    nch_r    <= num_ch;
                    nbeats_r <= num_beats;
                    ch       <= '0;
                    beat_cnt <= '0;
                end
                RUN: if (accept && final_beat) state <= DRAIN;
                DRAIN: if (cnt == '0) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                scale_tab[i] <= '0;
                zp_tab[i]    <= '0;
            end
        end else if (cfg_we && state == IDLE) begin
            scale_tab[cfg_addr] <= cfg_scale;
            zp_tab[cfg_addr]    <= cfg_zp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                last_mem[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= q_data_out;
                last_mem[wr_ptr] <= sr_last[QLAT];
                wr_ptr           <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: ;
            endcase
        end
    end
endmodule
